// File: rtl/int_ctrl_pkg.sv
// int_pkg: shared types and constants for the RAT8 interrupt controller.
//   int_state_t : controller FSM states (IDLE, IN_ISR, HOLD)
//   DB_W        : width of the optional debounce counter
package int_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IN_ISR,
        HOLD
    } int_state_t;

    localparam int DB_W = 8;

endpackage

// File: rtl/int_sync_edge.sv
// int_sync_edge: brings the asynchronous interrupt line into the clock domain
// and produces a one-cycle pulse on each rising edge.
// Optional feature macro: INT_DEBOUNCE_EN (adds a stability filter after the
// synchronizer; the edge is then taken from the filtered level).
// Ports:
//   i_clk   : system clock
//   i_rst_n : synchronous reset, active-low
//   i_async : raw external interrupt line
//   o_rise  : one-cycle pulse on a rising edge of the (filtered) level
module int_sync_edge
    import int_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    if (DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_bad_db_cycles
        $error("int_sync_edge: DB_CYCLES must be in 2..255");
    end

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
        end
    end

`ifdef INT_DEBOUNCE_EN
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] r_cnt;
    logic            r_filt;
    logic            r_filt_d;

    // r_cnt counts consecutive clocks where the synchronized input disagrees
    // with the filtered level; any agreement restarts the count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_filt   <= 1'b0;
            r_filt_d <= 1'b0;
        end else begin
            r_filt_d <= r_filt;
            if (r_sync2 != r_filt) begin
                if (r_cnt == DB_LAST) begin
                    r_filt <= r_sync2;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_rise = r_filt & ~r_filt_d;
`else
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_prev;
`endif

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: RAT8 interrupt controller. Holds the pending latch and the
// interrupt-enable flag, requests service from the control unit, and strobes
// the flags block to save C/Z on entry and restore them on RETIE/RETID.
// Optional feature macro: INT_DEBOUNCE_EN (debounce filter on INTR,
// window DB_CYCLES clocks).
// Ports:
//   CLK         : system clock
//   RESET_N     : synchronous reset, active-low
//   INTR        : external interrupt line (asynchronous)
//   I_SET/I_CLR : SEI / CLI from the control unit
//   INT_ACK     : control unit entering its interrupt state (pulse)
//   RETI        : RETIE/RETID executed (pulse); RETI_EN selects RETIE
//   INT_REQ     : interrupt request to the control unit
//   I_FLAG      : interrupt enable flag
//   FLG_SHAD_LD : save C/Z into the shadow registers
//   FLG_LD_SEL  : flags mux selects shadow values
//   FLG_RESTORE : load enable for C/Z during restore
module int_ctrl
    import int_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic INTR,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INT_ACK,
    input  logic RETI,
    input  logic RETI_EN,
    output logic INT_REQ,
    output logic I_FLAG,
    output logic FLG_SHAD_LD,
    output logic FLG_LD_SEL,
    output logic FLG_RESTORE
);

    int_state_t r_state;
    int_state_t w_next_state;
    logic       r_pending;
    logic       r_i_flag;
    logic       w_rise;
    logic       w_int_req;
    logic       w_enter;
    logic       w_restore;

    int_sync_edge #(
        .DB_CYCLES(DB_CYCLES)
    ) u_sync_edge (
        .i_clk  (CLK),
        .i_rst_n(RESET_N),
        .i_async(INTR),
        .o_rise (w_rise)
    );

    assign w_int_req = r_pending & r_i_flag & (r_state == IDLE);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_enter      = 1'b0;
        w_restore    = 1'b0;
        case (r_state)
            IDLE: begin
                if (INT_ACK && w_int_req) begin
                    w_enter      = 1'b1;
                    w_next_state = IN_ISR;
                end
            end
            IN_ISR: begin
                if (RETI) begin
                    w_restore    = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // A new edge outranks the entry clear so an edge coinciding with the
    // acknowledge is not lost. Entry clear and RETI load outrank CLI/SEI.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_pending <= 1'b0;
            r_i_flag  <= 1'b0;
        end else begin
            if (w_rise) begin
                r_pending <= 1'b1;
            end else if (w_enter) begin
                r_pending <= 1'b0;
            end

            if (w_enter) begin
                r_i_flag <= 1'b0;
            end else if (w_restore) begin
                r_i_flag <= RETI_EN;
            end else if (I_CLR) begin
                r_i_flag <= 1'b0;
            end else if (I_SET) begin
                r_i_flag <= 1'b1;
            end
        end
    end

    assign INT_REQ     = w_int_req;
    assign I_FLAG      = r_i_flag;
    assign FLG_SHAD_LD = w_enter;
    assign FLG_LD_SEL  = w_restore;
    assign FLG_RESTORE = w_restore;

endmodule
